ps2_kbd_rx: RTL
===============

// Module: ps2_kbd_rx
// PURPOSE
// PS/2 keyboard receiver that turns the raw ps2_clk/ps2_data pins into byte-wide scan codes.
// It drives xgsoc's ps2_kbd_code_i, ps2_kbd_strobe_i and ps2_kbd_err_i inputs on FPGA targets.
// Covered functions: pin synchronisation, glitch filtering, 11-bit frame capture, parity/framing checks and inter-bit timeout.
// Receive only: no host-to-device transmit.
// PARAMETERS
// FREQ_HZ      1000000  system clock frequency in Hz
// FILTER_LEN   8        consecutive stable cycles required before a filtered pin changes (>=2)
// TIMEOUT_US   2000     max gap between falling ps2 clock edges inside a frame, in us
// Derived: TIMEOUT_CYC = FREQ_HZ/1000000*TIMEOUT_US; counter width = $clog2(TIMEOUT_CYC+1)
// PORTS
// clk          in   1  system clock
// reset_n_i    in   1  asynchronous active-low reset
// ps2_clk_i    in   1  raw PS/2 clock pin, asynchronous, idles high
// ps2_data_i   in   1  raw PS/2 data pin, asynchronous, idles high
// code_o       out  8  last good scan code; held until the next good frame
// strobe_o     out  1  one-cycle pulse: code_o updated this cycle
// err_o        out  1  one-cycle pulse: frame discarded (parity, start, stop or timeout)
// BEHAVIOUR
// Reset (async assert, sync release to clk):
//   code_o=0x00, strobe_o=0, err_o=0; filtered clk/data=1; state=IDLE; counters=0.
// Input front end:
//   - 2-FF synchroniser on each pin.
//   - Per-pin filter: the filtered value takes the synchronised value after FILTER_LEN
//     consecutive equal cycles; shorter pulses are ignored.
//   - Falling edge (fall) = filtered clk 1 in the previous cycle, 0 in this one.
//   - On fall, filtered data is sampled in the same cycle.
// FSM:
//   IDLE:   on fall with data=0 -> SHIFT, bitcnt=0.
//           On fall with data=1 (bad start): stay IDLE, no err.
//   SHIFT:  on fall, shift data into shreg LSB first (shreg={d,shreg[7:1]}), bitcnt++.
//           After the 8th bit -> PARITY.
//   PARITY: on fall, capture the parity bit -> STOP.
//   STOP:   on fall, check ^shreg ^ parity == 1 (odd) and stop bit == 1.
//           Both pass: code_o<=shreg, strobe_o=1 for one cycle.
//           Either fails: err_o=1 for one cycle, code_o unchanged.
//           Always -> IDLE.
// Timing and timeout:
//   - Latency: strobe_o/err_o are asserted in the cycle after the stop-bit fall (registered).
//   - Timeout counter clears on every fall and counts in every cycle while state!=IDLE.
//   - Counter reaches TIMEOUT_CYC: err_o pulse, state -> IDLE, shreg cleared.
//   - Fall and timeout in the same cycle: the fall wins and the counter clears.
// Exclusivity and mid-operation events:
//   - strobe_o and err_o are never both 1 and never high for more than one cycle.
//   - Reset mid-frame aborts the frame with no strobe/err.
//     The receiver then resyncs on the next start bit.
//   - A frame arriving while code_o is unread still overwrites it; no backpressure.
//     The consumer must sample on strobe_o.
// TESTING
// Bench: FREQ_HZ=1000000, FILTER_LEN=8, TIMEOUT_US=2000, ps2 clock period 80us (40 cycles low / 40 high).
// 1 Frame 0x1C, parity 0, stop 1 -> one strobe_o pulse with code_o=0x1C; err_o stays 0.
// 2 Frames 0xE0 (p=0) then 0x75 (p=0), back-to-back
//   -> two strobes: code_o=0xE0, then 0x75.
// 3 Frame 0x1C with parity 1 -> one err_o pulse; no strobe; code_o keeps its previous value.
// 4 Frame 0xF0 with stop bit 0 -> err_o pulse; no strobe.
// 5 Timeout then recovery:
//   - Stop after 5 data bits and hold clk high for >2000 cycles.
//     -> err_o pulse exactly 2000 cycles after the last fall; FSM returns to IDLE.
//   - Then send frame 0xF0 (p=1) -> strobe_o with code_o=0xF0.
// 6 Glitch and reset robustness:
//   - 4-cycle low glitch on ps2_clk_i while IDLE -> no state change, no pulses.
//   - Assert reset_n_i after bit 3 of a frame, then send 0x1C -> only the 0x1C strobe and no err_o.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx -- PS/2 keyboard receiver (receive only).
//
// Turns the raw PS/2 clock/data pins into byte-wide scan codes. Both pins are
// synchronised and glitch-filtered. Then the 11-bit frame (start, 8 data bits
// LSB first, odd parity, stop) is captured on filtered falling clock edges.
// A stalled frame is abandoned after TIMEOUT_US without a clock fall.
//
// Ports:
//   clk          in   system clock
//   reset_n_i    in   asynchronous active-low reset (release must be synchronous to clk)
//   ps2_clk_i    in   raw PS/2 clock pin (asynchronous, idles high)
//   ps2_data_i   in   raw PS/2 data pin (asynchronous, idles high)
//   code_o       out  last good scan code, held until the next good frame
//   strobe_o     out  one-cycle pulse: code_o updated this cycle
//   err_o        out  one-cycle pulse: frame discarded (parity/start/stop/timeout)
module ps2_kbd_rx #(
  parameter int FREQ_HZ    = 1000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       strobe_o,
  output logic       err_o
);

  localparam int TIMEOUT_CYC = FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TCW         = $clog2(TIMEOUT_CYC + 1);
  localparam int FCW         = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Front end: index 0 = clock pin, index 1 = data pin.
  // ---------------------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] pin_filt;

  assign pin_raw = {ps2_data_i, ps2_clk_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pin
      logic           sync1_q;
      logic           sync2_q;
      logic           filt_q;
      logic [FCW-1:0] cnt_q;

      // The filtered value only follows the synchroniser after FILTER_LEN
      // consecutive cycles of disagreement; any agreement restarts the count.
      always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          filt_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          sync1_q <= pin_raw[gi];
          sync2_q <= sync1_q;
          if (sync2_q == filt_q) begin
            cnt_q <= '0;
          end else if (cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_q <= sync2_q;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign pin_filt[gi] = filt_q;
    end
  endgenerate

  logic clk_prev_q;
  logic fall;
  logic data_bit;

  assign fall     = clk_prev_q & ~pin_filt[0];
  assign data_bit = pin_filt[1];

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) clk_prev_q <= 1'b1;
    else            clk_prev_q <= pin_filt[0];
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t         state_q,  state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shreg_q,  shreg_d;
  logic           par_q,    par_d;
  logic [7:0]     code_q,   code_d;
  logic           strobe_q, strobe_d;
  logic           err_q,    err_d;
  logic [TCW-1:0] tcnt_q,   tcnt_d;
  logic [TCW-1:0] tcnt_inc;

  assign tcnt_inc = tcnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    tcnt_d   = (state_q == IDLE) ? '0 : tcnt_inc;

    if (fall) begin
      // A fall always wins over a simultaneous timeout.
      tcnt_d = '0;
      unique case (state_q)
        IDLE: begin
          // A high start bit is silently ignored.
          if (!data_bit) begin
            state_d  = SHIFT;
            bitcnt_d = '0;
          end
        end
        SHIFT: begin
          shreg_d  = {data_bit, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_bit;
          state_d = STOP;
        end
        STOP: begin
          if ((^shreg_q ^ par_q) && data_bit) begin
            code_d   = shreg_q;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tcnt_inc == TCW'(TIMEOUT_CYC)) begin
      err_d   = 1'b1;
      state_d = IDLE;
      shreg_d = '0;
      tcnt_d  = '0;
    end
  end

  assign code_o   = code_q;
  assign strobe_o = strobe_q;
  assign err_o    = err_q;

endmodule
